// File: rtl/snake_state_reader.sv
// ---------------------------------------------------------------------------
// snake_state_reader
//
// Takes a snapshot of the packed snake game state on request and streams it
// out one item per accepted transfer, using a valid/ready handshake.
//   items 0 .. NUM_CELLS-1          : {30'b0, cell[i]}   (2-bit board cells)
//   items NUM_CELLS .. NUM_ITEMS-1  : word[i-NUM_CELLS]  (32-bit state words)
// While a stream is running, later changes on state_in have no effect on it.
//
// Ports
//   clock     : sole clock, rising edge
//   reset     : asynchronous, active-high; aborts any stream, no done pulse
//   state_in  : packed game state (cells at the low end, then words)
//   start     : single-cycle request; honoured only while idle
//   out_ready : consumer accepts the current item on this edge
//   out_valid : out_index / out_data hold a valid item
//   out_index : item number, 0 .. NUM_ITEMS-1
//   out_data  : item payload
//   busy      : snapshot held, stream in progress
//   done      : one-cycle pulse after the last item is accepted
// ---------------------------------------------------------------------------
module snake_state_reader #(
   parameter  int NUM_CELLS = 100,
   parameter  int NUM_WORDS = 8,
   localparam int STATE_W   = 2 * NUM_CELLS + 32 * NUM_WORDS,
   localparam int NUM_ITEMS = NUM_CELLS + NUM_WORDS,
   localparam int IDX_W     = $clog2(NUM_ITEMS)
) (
   input  logic               clock,
   input  logic               reset,
   input  logic [STATE_W-1:0] state_in,
   input  logic               start,
   input  logic               out_ready,
   output logic               out_valid,
   output logic [IDX_W-1:0]   out_index,
   output logic [31:0]        out_data,
   output logic               busy,
   output logic               done
);

   typedef enum logic [1:0] {
      IDLE,
      STREAM,
      DONE
   } state_t;

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ITEMS - 1);

   state_t             state;
   logic [STATE_W-1:0] snapshot;
   logic [IDX_W-1:0]   next_index;

   // Selects one item out of a packed state vector. Shifting instead of a
   // variable part-select keeps the index arithmetic width-clean.
   function automatic logic [31:0] item_of(input logic [STATE_W-1:0] s,
                                           input logic [IDX_W-1:0]   idx);
      logic [STATE_W-1:0] shifted;
      int                 i;
      // NOTE: every local gets a value on every path; a variable left
      // unassigned on some path is how latches sneak into combinational logic.
      item_of = '0;
      i       = int'(idx);
      if (i < NUM_CELLS) begin
         shifted = s >> (2 * i);
         item_of = {30'b0, shifted[1:0]};
      end else begin
         shifted = s >> (2 * NUM_CELLS + 32 * (i - NUM_CELLS));
         item_of = shifted[31:0];
      end
   endfunction

   assign next_index = out_index + 1'b1;

   // Single FSM; all outputs are registered. Data for item N+1 is fetched
   // from the snapshot on the edge that accepts item N, so a continuously
   // ready consumer sees one item per cycle.
   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples the pre-edge values regardless of statement order.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         // NOTE: the snapshot is reset along with the control registers, so
         // no stale game state survives a reset even though it is wide.
         state     <= IDLE;
         snapshot  <= '0;
         out_index <= '0;
         out_data  <= '0;
         out_valid <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  // Item 0 comes straight from state_in: the snapshot is
                  // being written on this same edge.
                  snapshot  <= state_in;
                  out_index <= '0;
                  out_data  <= item_of(state_in, {IDX_W{1'b0}});
                  out_valid <= 1'b1;
                  busy      <= 1'b1;
                  state     <= STREAM;
               end
            end

            STREAM: begin
               // out_valid is always high here, so out_ready alone marks a
               // transfer. Without it everything holds.
               if (out_ready) begin
                  if (out_index == LAST_IDX) begin
                     // Index stays at the last item; it never wraps.
                     out_valid <= 1'b0;
                     busy      <= 1'b0;
                     done      <= 1'b1;
                     state     <= DONE;
                  end else begin
                     out_index <= next_index;
                     out_data  <= item_of(snapshot, next_index);
                  end
               end
            end

            DONE: begin
               // start is deliberately not looked at here.
               done  <= 1'b0;
               state <= IDLE;
            end

            default: begin
               out_valid <= 1'b0;
               busy      <= 1'b0;
               done      <= 1'b0;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_snake_state_reader.sv
// ---------------------------------------------------------------------------
// tb_snake_state_reader
//
// Self-checking bench for snake_state_reader. Expected items come from a
// reference function that slices the captured state vector arithmetically;
// a negedge monitor logs every accepted transfer and counts done pulses.
// ---------------------------------------------------------------------------
module tb_snake_state_reader;

   localparam int NC = 100;
   localparam int NW = 8;
   localparam int SW = 2 * NC + 32 * NW;
   localparam int NI = NC + NW;

   logic          clock = 1'b0;
   logic          reset = 1'b0;
   logic [SW-1:0] state_in = '0;
   logic          start = 1'b0;
   logic          out_ready = 1'b0;
   logic          out_valid;
   logic [6:0]    out_index;
   logic [31:0]   out_data;
   logic          busy;
   logic          done;

   int          total = 0;
   int          bad = 0;
   int          done_cnt = 0;
   int          log_idx[$];
   logic [31:0] log_dat[$];

   snake_state_reader #(
      .NUM_CELLS(NC),
      .NUM_WORDS(NW)
   ) dut (
      .clock    (clock),
      .reset    (reset),
      .state_in (state_in),
      .start    (start),
      .out_ready(out_ready),
      .out_valid(out_valid),
      .out_index(out_index),
      .out_data (out_data),
      .busy     (busy),
      .done     (done)
   );

   always #5 clock = ~clock;

   // Transfer log and done counter, sampled mid-cycle.
   always @(negedge clock) begin
      if (done === 1'b1) done_cnt++;
      if (reset === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
         log_idx.push_back(int'(out_index));
         log_dat.push_back(out_data);
      end
   end

   // Reference model: item k of a state vector.
   function automatic logic [31:0] exp_item(input logic [SW-1:0] s, input int k);
      logic [SW-1:0] sh;
      if (k < NC) begin
         sh = s >> (2 * k);
         return {30'b0, sh[1:0]};
      end
      sh = s >> (2 * NC + 32 * (k - NC));
      return sh[31:0];
   endfunction

   function automatic logic [SW-1:0] rand_state();
      logic [SW-1:0] s = '0;
      for (int i = 0; i < (SW + 31) / 32; i++) s = (s << 32) | SW'($urandom);
      return s;
   endfunction

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic launch(input logic [SW-1:0] s);
      state_in = s;
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic clear_log();
      log_idx.delete();
      log_dat.delete();
   endtask

   // ---------------------------------------------------------------------
   task automatic test_reset();
      #2 reset = 1'b1;
      #1;
      total++;
      if ({out_valid, busy, done} !== 3'b000) begin
         bad++; $display("FAIL reset_flags got=%b want=000", {out_valid, busy, done});
      end
      total++;
      if (out_index !== 7'd0 || out_data !== 32'd0) begin
         bad++; $display("FAIL reset_outputs got idx=%0d data=%h want 0/0", out_index, out_data);
      end
      step();
      step();
      reset = 1'b0;
      step();
      total++;
      if ({out_valid, busy, done} !== 3'b000) begin
         bad++; $display("FAIL idle_after_reset got=%b want=000", {out_valid, busy, done});
      end
   endtask

   // Known cells/words, continuous ready: 108 items in 108 cycles.
   task automatic test_full_stream();
      logic [SW-1:0] s = rand_state();
      int d0 = done_cnt;
      s[2*5 +: 2] = 2'b11;
      s[2*NC +: 32] = 32'h0000_002A;
      out_ready = 1'b1;
      launch(s);
      total++;
      if (out_valid !== 1'b1 || busy !== 1'b1) begin
         bad++; $display("FAIL first_valid got valid=%b busy=%b want 1/1", out_valid, busy);
      end
      for (int k = 0; k < NI; k++) begin
         total++;
         if (out_valid !== 1'b1 || out_index !== 7'(k) || out_data !== exp_item(s, k)) begin
            bad++;
            $display("FAIL full_item got v=%b idx=%0d data=%h want v=1 idx=%0d data=%h",
                     out_valid, out_index, out_data, k, exp_item(s, k));
         end
         if (k == 5) begin
            total++;
            if (out_data !== 32'h3) begin
               bad++; $display("FAIL cell5 got=%h want=00000003", out_data);
            end
         end
         if (k == 100) begin
            total++;
            if (out_data !== 32'h2A) begin
               bad++; $display("FAIL word100 got=%h want=0000002a", out_data);
            end
         end
         step();
      end
      total++;
      if ({done, out_valid, busy} !== 3'b100) begin
         bad++; $display("FAIL done_pulse got done/valid/busy=%b want=100", {done, out_valid, busy});
      end
      step();
      total++;
      if ({done, out_valid, busy} !== 3'b000) begin
         bad++; $display("FAIL done_single got done/valid/busy=%b want=000", {done, out_valid, busy});
      end
      total++;
      if (out_index !== 7'd107 || out_data !== exp_item(s, 107)) begin
         bad++; $display("FAIL idle_hold got idx=%0d data=%h want 107/%h", out_index, out_data, exp_item(s, 107));
      end
      total++;
      if (done_cnt - d0 !== 1) begin
         bad++; $display("FAIL full_done_count got=%0d want=1", done_cnt - d0);
      end
   endtask

   // Stall for 3 cycles while item 50 is presented.
   task automatic test_stall();
      logic [SW-1:0] s = rand_state();
      clear_log();
      out_ready = 1'b1;
      launch(s);
      for (int n = 0; n < 200 && !(out_valid === 1'b1 && out_index === 7'd50); n++) step();
      total++;
      if (out_index !== 7'd50) begin
         bad++; $display("FAIL stall_reach got idx=%0d want=50", out_index);
      end
      out_ready = 1'b0;
      for (int c = 0; c < 3; c++) begin
         step();
         total++;
         if (out_valid !== 1'b1 || out_index !== 7'd50 || out_data !== exp_item(s, 50)) begin
            bad++;
            $display("FAIL stall_hold got v=%b idx=%0d data=%h want v=1 idx=50 data=%h",
                     out_valid, out_index, out_data, exp_item(s, 50));
         end
      end
      out_ready = 1'b1;
      for (int n = 0; n < 200 && done !== 1'b1; n++) step();
      total++;
      if (done !== 1'b1) begin
         bad++; $display("FAIL stall_done got=%b want=1", done);
      end
      total++;
      if (log_idx.size() != NI) begin
         bad++; $display("FAIL stall_log_len got=%0d want=%0d", log_idx.size(), NI);
      end else begin
         for (int k = 0; k < NI; k++) begin
            total++;
            if (log_idx[k] != k || log_dat[k] !== exp_item(s, k)) begin
               bad++;
               $display("FAIL stall_log got idx=%0d data=%h want idx=%0d data=%h",
                        log_idx[k], log_dat[k], k, exp_item(s, k));
            end
         end
      end
      step();
   endtask

   // state_in goes all-ones right after capture.
   task automatic test_snapshot();
      logic [SW-1:0] s = rand_state();
      out_ready = 1'b1;
      launch(s);
      state_in = '1;
      for (int k = 0; k < NI; k++) begin
         total++;
         if (out_index !== 7'(k) || out_data !== exp_item(s, k)) begin
            bad++;
            $display("FAIL snapshot_item got idx=%0d data=%h want idx=%0d data=%h",
                     out_index, out_data, k, exp_item(s, k));
         end
         step();
      end
      total++;
      if (done !== 1'b1) begin
         bad++; $display("FAIL snapshot_done got=%b want=1", done);
      end
      step();
   endtask

   // start pulsed mid-stream with a different state_in.
   task automatic test_restart_ignored();
      logic [SW-1:0] s = rand_state();
      int d0 = done_cnt;
      clear_log();
      out_ready = 1'b1;
      launch(s);
      for (int n = 0; n < 200 && out_index !== 7'd20; n++) step();
      state_in = ~s;
      start = 1'b1;
      step();
      start = 1'b0;
      total++;
      if (out_index !== 7'd21 || out_data !== exp_item(s, 21)) begin
         bad++; $display("FAIL restart_next got idx=%0d data=%h want 21/%h", out_index, out_data, exp_item(s, 21));
      end
      for (int n = 0; n < 200 && done !== 1'b1; n++) step();
      step();
      step();
      step();
      total++;
      if (done_cnt - d0 !== 1) begin
         bad++; $display("FAIL restart_done_count got=%0d want=1", done_cnt - d0);
      end
      total++;
      if (out_valid !== 1'b0 || out_index !== 7'd107) begin
         bad++; $display("FAIL restart_idle got v=%b idx=%0d want 0/107", out_valid, out_index);
      end
      total++;
      if (log_idx.size() != NI) begin
         bad++; $display("FAIL restart_log_len got=%0d want=%0d", log_idx.size(), NI);
      end else begin
         for (int k = 0; k < NI; k++) begin
            total++;
            if (log_idx[k] != k || log_dat[k] !== exp_item(s, k)) begin
               bad++;
               $display("FAIL restart_log got idx=%0d data=%h want idx=%0d data=%h",
                        log_idx[k], log_dat[k], k, exp_item(s, k));
            end
         end
      end
   endtask

   // Asynchronous reset at item 60, then start on the first edge after release.
   task automatic test_reset_mid();
      logic [SW-1:0] s  = rand_state();
      logic [SW-1:0] s2 = rand_state();
      int d0 = done_cnt;
      out_ready = 1'b1;
      launch(s);
      for (int n = 0; n < 200 && out_index !== 7'd60; n++) step();
      total++;
      if (out_index !== 7'd60) begin
         bad++; $display("FAIL rst_reach got idx=%0d want=60", out_index);
      end
      #2 reset = 1'b1;
      #1;
      total++;
      if ({out_valid, busy, done} !== 3'b000 || out_index !== 7'd0 || out_data !== 32'd0) begin
         bad++;
         $display("FAIL rst_immediate got v/b/d=%b idx=%0d data=%h want 000/0/0",
                  {out_valid, busy, done}, out_index, out_data);
      end
      step();
      step();
      step();
      total++;
      if (done_cnt != d0) begin
         bad++; $display("FAIL rst_no_done got=%0d want=0", done_cnt - d0);
      end
      clear_log();
      reset = 1'b0;
      launch(s2);
      total++;
      if (out_valid !== 1'b1 || out_index !== 7'd0 || out_data !== exp_item(s2, 0)) begin
         bad++;
         $display("FAIL rst_first_start got v=%b idx=%0d data=%h want 1/0/%h",
                  out_valid, out_index, out_data, exp_item(s2, 0));
      end
      for (int n = 0; n < 200 && done !== 1'b1; n++) step();
      step();
      total++;
      if (done_cnt - d0 !== 1) begin
         bad++; $display("FAIL rst_done_count got=%0d want=1", done_cnt - d0);
      end
      total++;
      if (log_idx.size() != NI) begin
         bad++; $display("FAIL rst_log_len got=%0d want=%0d", log_idx.size(), NI);
      end else begin
         for (int k = 0; k < NI; k++) begin
            total++;
            if (log_idx[k] != k || log_dat[k] !== exp_item(s2, k)) begin
               bad++;
               $display("FAIL rst_log got idx=%0d data=%h want idx=%0d data=%h",
                        log_idx[k], log_dat[k], k, exp_item(s2, k));
            end
         end
      end
   endtask

   // Five streams with random ready and stray start pulses, >= 1000 cycles.
   task automatic test_random();
      int d0 = done_cnt;
      int cycles = 0;
      for (int st = 0; st < 5; st++) begin
         logic [SW-1:0] s = rand_state();
         int gap = $urandom_range(0, 3);
         for (int g = 0; g < gap; g++) begin
            step();
            cycles++;
         end
         clear_log();
         out_ready = ($urandom_range(0, 3) != 0);
         launch(s);
         cycles++;
         for (int n = 0; n < 400 && done !== 1'b1; n++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            start = ($urandom_range(0, 15) == 0);
            state_in = rand_state();
            step();
            cycles++;
         end
         start = 1'b0;
         total++;
         if (done !== 1'b1) begin
            bad++; $display("FAIL rand_done stream=%0d got=%b want=1", st, done);
         end
         total++;
         if (log_idx.size() != NI) begin
            bad++; $display("FAIL rand_log_len stream=%0d got=%0d want=%0d", st, log_idx.size(), NI);
         end else begin
            for (int k = 0; k < NI; k++) begin
               total++;
               if (log_idx[k] != k || log_dat[k] !== exp_item(s, k)) begin
                  bad++;
                  $display("FAIL rand_item stream=%0d got idx=%0d data=%h want idx=%0d data=%h",
                           st, log_idx[k], log_dat[k], k, exp_item(s, k));
               end
            end
         end
         step();
         cycles++;
      end
      while (cycles < 1000) begin
         out_ready = ($urandom_range(0, 1) != 0);
         step();
         cycles++;
      end
      total++;
      if (done_cnt - d0 !== 5) begin
         bad++; $display("FAIL rand_done_count got=%0d want=5", done_cnt - d0);
      end
      total++;
      if (out_valid !== 1'b0 || busy !== 1'b0) begin
         bad++; $display("FAIL rand_final_idle got v=%b busy=%b want 0/0", out_valid, busy);
      end
   endtask

   initial begin
      test_reset();
      test_full_stream();
      test_stall();
      test_snapshot();
      test_restart_ignored();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1);
   end

endmodule
